// File: rtl/adc_proto_pkg.sv
// Shared constants and state encodings for the ADC query responder.
// ADC_RESP_CHECKSUM_EN: when defined, every reply carries a third XOR checksum byte.
package adc_proto_pkg;

    localparam logic [7:0] CMD_BASE = 8'hA0;
    localparam int         NUM_CH   = 4;
    localparam int         VALUE_W  = 10;

`ifdef ADC_RESP_CHECKSUM_EN
    localparam int REPLY_BYTES = 3;
`else
    localparam int REPLY_BYTES = 2;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_GAP, TX_SEND} tx_state_t;
    typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;

    // True for the channel-read commands CMD_BASE+1 .. CMD_BASE+NUM_CH.
    function automatic logic is_read_cmd(input logic [7:0] b);
        return (b > CMD_BASE) && (b <= CMD_BASE + 8'(NUM_CH));
    endfunction

endpackage

// File: rtl/adc_uart_tx.sv
// 8N1 byte serializer. A start accepted while ready loads a byte; ready is
// also high in the final stop-bit cycle so the next byte follows with no gap.
module adc_uart_tx
    import adc_proto_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk12MHz,
    input  logic       resetq,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       tx
);

    localparam int              TMR_W    = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    ser_state_t       state, state_next;
    logic [TMR_W-1:0] tmr;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             tick;

    assign tick  = (tmr == '0);
    assign done  = (state == SER_STOP) && tick;
    assign ready = (state == SER_IDLE) || done;

    // State register; reset forces the line idle immediately.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            state <= SER_IDLE;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
            state <= state_next;
        end
    end

    // Next state and line level; tx is decoded from registered state only.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_next = state;
        tx         = 1'b1;
        unique case (state)
            SER_IDLE:  if (start) state_next = SER_START;
            SER_START: begin
                tx = 1'b0;
                if (tick) state_next = SER_DATA;
            end
            SER_DATA: begin
                tx = shreg[0];
                if (tick && bit_idx == 3'd7) state_next = SER_STOP;
            end
            SER_STOP:  if (tick) state_next = start ? SER_START : SER_IDLE;
            default:   state_next = SER_IDLE;
        endcase
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            tmr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else if (ready && start) begin
            tmr     <= TMR_LAST;
            bit_idx <= '0;
            shreg   <= data;
        end else if (state != SER_IDLE) begin
            if (tick) begin
                tmr <= TMR_LAST;
                if (state == SER_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                tmr <= tmr - 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_responder.sv
// UART responder for the ADC query protocol: decodes 0xA1..0xA4 on rx and
// replies on tx with the selected channel value, one reply active plus one
// pending. ADC_RESP_CHECKSUM_EN appends an XOR checksum byte to each reply.
module adc_responder #(
    parameter int CLKS_PER_BIT = 104,
    parameter int RESP_GAP     = 16,
    parameter int VALUE_W      = adc_proto_pkg::VALUE_W
) (
    input  logic               clk12MHz,
    input  logic               resetq,
    input  logic               rx,
    output logic               tx,
    input  logic [VALUE_W-1:0] value1,
    input  logic [VALUE_W-1:0] value2,
    input  logic [VALUE_W-1:0] value3,
    input  logic [VALUE_W-1:0] value4,
    output logic               cmd_ok,
    output logic               cmd_bad,
    output logic               overrun,
    output logic               busy
);
    import adc_proto_pkg::*;

    localparam int               TMR_W     = $clog2(CLKS_PER_BIT);
    localparam int               GAP_W     = $clog2(RESP_GAP + 1);
    localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(RESP_GAP - 1);
    localparam logic [1:0]       LAST_BYTE = 2'(REPLY_BYTES - 1);

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync, rx_prev, rx_fall, rx_tick;
    logic [TMR_W-1:0] rx_tmr;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_done, rx_stop_ok;

    tx_state_t          tx_state, tx_next;
    logic [GAP_W-1:0]   gap_tmr;
    logic [1:0]         byte_idx, send_idx;
    logic [VALUE_W-1:0] act_val, slot_val, cmd_val;
    logic               slot_full, cmd_valid;
    logic               last_done, take_slot, tx_free, load_active, load_slot;
    logic               ser_start, ser_ready, ser_done;
    logic [7:0]         ser_data, byte_hi, byte_lo;

    assign rx_fall = rx_prev && !rx_sync;
    assign rx_tick = (rx_tmr == '0);

    // Two-flop synchronizer plus one flop of history for start-edge detection.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX state register.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    // RX next state: a start bit that is high again at mid-bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX timer, LSB-first shifter and the stop-sample result for decode.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            rx_tmr     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_done    <= 1'b0;
            rx_stop_ok <= 1'b0;
        end else begin
            rx_done <= (rx_state == RX_STOP) && rx_tick;
            unique case (rx_state)
                RX_IDLE: begin
                    rx_tmr <= HALF_LAST;
                    rx_idx <= '0;
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_tmr   <= BIT_LAST;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_idx   <= rx_idx + 3'd1;
                    end else begin
                        rx_tmr <= rx_tmr - 1'b1;
                    end
                end
                default: begin
                    rx_tmr <= rx_tick ? BIT_LAST : rx_tmr - 1'b1;
                    if (rx_state == RX_STOP && rx_tick) rx_stop_ok <= rx_sync;
                end
            endcase
        end
    end

    // Decode and queue arbitration; a finishing reply frees the slot first.
    always_comb begin
        cmd_valid = rx_done && rx_stop_ok && is_read_cmd(rx_shift);
        case (rx_shift[2:0])
            3'd1:    cmd_val = value1;
            3'd2:    cmd_val = value2;
            3'd3:    cmd_val = value3;
            default: cmd_val = value4;
        endcase
        last_done   = (tx_state == TX_SEND) && ser_done && (byte_idx == LAST_BYTE);
        take_slot   = last_done && slot_full;
        tx_free     = (tx_state == TX_IDLE) || (last_done && !slot_full);
        cmd_ok      = cmd_valid && (!slot_full || take_slot);
        overrun     = cmd_valid && !cmd_ok;
        cmd_bad     = rx_done && !cmd_valid;
        load_active = cmd_ok && tx_free;
        load_slot   = cmd_ok && !tx_free;
        busy        = (tx_state != TX_IDLE) || slot_full;
    end

    // TX sequencer state register.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) tx_state <= TX_IDLE;
        else         tx_state <= tx_next;
    end

    // TX sequencer next state and byte launch requests.
    always_comb begin
        tx_next   = tx_state;
        ser_start = 1'b0;
        unique case (tx_state)
            TX_IDLE: if (cmd_ok) tx_next = TX_GAP;
            TX_GAP: begin
                if (gap_tmr == '0 && ser_ready) begin
                    ser_start = 1'b1;
                    tx_next   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (ser_done) begin
                    if (byte_idx != LAST_BYTE)   ser_start = 1'b1;
                    else if (slot_full || cmd_ok) tx_next  = TX_GAP;
                    else                          tx_next  = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Reply byte selection from the snapshotted value.
    always_comb begin
        send_idx = (tx_state == TX_GAP) ? 2'd0 : byte_idx + 2'd1;
        byte_hi  = 8'(act_val >> 8);
        byte_lo  = act_val[7:0];
        case (send_idx)
            2'd0:    ser_data = byte_hi;
`ifdef ADC_RESP_CHECKSUM_EN
            2'd2:    ser_data = byte_hi ^ byte_lo;
`endif
            default: ser_data = byte_lo;
        endcase
    end

    // Gap timer, byte counter, active value and pending slot.
    always_ff @(posedge clk12MHz or negedge resetq) begin
        if (!resetq) begin
            gap_tmr   <= '0;
            byte_idx  <= '0;
            act_val   <= '0;
            slot_val  <= '0;
            slot_full <= 1'b0;
        end else begin
            if (tx_next == TX_GAP && tx_state != TX_GAP) gap_tmr <= GAP_LAST;
            else if (tx_state == TX_GAP && gap_tmr != '0) gap_tmr <= gap_tmr - 1'b1;

            if (ser_start) byte_idx <= send_idx;

            if (take_slot)        act_val <= slot_val;
            else if (load_active) act_val <= cmd_val;

            if (load_slot) begin
                slot_full <= 1'b1;
                slot_val  <= cmd_val;
            end else if (take_slot) begin
                slot_full <= 1'b0;
            end
        end
    end

    adc_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk12MHz (clk12MHz),
        .resetq   (resetq),
        .start    (ser_start),
        .data     (ser_data),
        .ready    (ser_ready),
        .done     (ser_done),
        .tx       (tx)
    );

endmodule

// File: tb/tb_adc_responder.sv
// Directed bench for adc_responder: drives 8N1 commands on rx, decodes tx
// with an independent UART monitor and checks bytes, pulses and timing.
module tb_adc_responder;

    localparam int CPB   = 104;
    localparam int GAP   = 16;
    localparam int FRAME = 10 * CPB;
`ifdef ADC_RESP_CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic       clk12MHz = 1'b0;
    logic       resetq;
    logic       rx;
    logic       tx;
    logic [9:0] value1, value2, value3, value4;
    logic       cmd_ok, cmd_bad, overrun, busy;

    always #5 clk12MHz = ~clk12MHz;

    adc_responder #(
        .CLKS_PER_BIT (CPB),
        .RESP_GAP     (GAP),
        .VALUE_W      (10)
    ) dut (
        .clk12MHz (clk12MHz),
        .resetq   (resetq),
        .rx       (rx),
        .tx       (tx),
        .value1   (value1),
        .value2   (value2),
        .value3   (value3),
        .value4   (value4),
        .cmd_ok   (cmd_ok),
        .cmd_bad  (cmd_bad),
        .overrun  (overrun),
        .busy     (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int cnt_ok = 0, cnt_bad = 0, cnt_ovr = 0, last_ok_cyc = 0;
    int stop_errs = 0;
    int rd = 0;
    logic [7:0] mon_q[$];
    int         start_q[$];

    always @(posedge clk12MHz) cyc <= cyc + 1;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk12MHz) begin
        if (cmd_ok) begin
            cnt_ok      = cnt_ok + 1;
            last_ok_cyc = cyc;
        end
        if (cmd_bad) cnt_bad = cnt_bad + 1;
        if (overrun) cnt_ovr = cnt_ovr + 1;
    end

    // Reference UART receiver on tx, sampling each bit at its centre.
    initial begin : tx_monitor
        logic [7:0] b;
        b = '0;
        forever begin
            @(posedge clk12MHz); #1;
            if (tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CPB / 2) begin @(posedge clk12MHz); #1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(posedge clk12MHz); #1; end
                    b[i] = tx;
                end
                repeat (CPB) begin @(posedge clk12MHz); #1; end
                if (tx !== 1'b1) stop_errs = stop_errs + 1;
                mon_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #(80000 * 10);
        $display("FAIL watchdog: observed no end of run, expected finish within 80000 cycles");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk12MHz);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk12MHz);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk12MHz);
        rx = 1'b1;
    endtask

    task automatic wait_idle(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 4 * NB * FRAME; i++) begin
            @(negedge clk12MHz);
            if (!busy) begin
                at = cyc;
                break;
            end
        end
        check({tag, " idle reached"}, 32'(at >= 0), 32'd1);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (rd < mon_q.size()) ? mon_q[rd] : 8'hxx;
        rd++;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] ck);
        expect_byte({tag, " byte0"}, b0);
        expect_byte({tag, " byte1"}, b1);
`ifdef ADC_RESP_CHECKSUM_EN
        expect_byte({tag, " checksum"}, ck);
`else
        if (ck === 8'hxx) $display("note: checksum argument unset for %s", tag);
`endif
    endtask

    initial begin : stimulus
        int ok0, bad0, ovr0, s0, q0, at;

        resetq = 1'b0;
        rx     = 1'b1;
        value1 = '0;
        value2 = '0;
        value3 = 10'h2A5;
        value4 = '0;
        repeat (3) @(negedge clk12MHz);
        check("reset tx",      32'(tx),      32'd1);
        check("reset busy",    32'(busy),    32'd0);
        check("reset cmd_ok",  32'(cmd_ok),  32'd0);
        check("reset cmd_bad", 32'(cmd_bad), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        resetq = 1'b1;
        repeat (10) @(negedge clk12MHz);

        // Read channel 3: reply 0x02, 0xA5 after the response gap.
        ok0 = cnt_ok; bad0 = cnt_bad; s0 = start_q.size();
        send_byte(8'hA3, 1'b1);
        wait_idle("t1", at);
        check("t1 cmd_ok count",  32'(cnt_ok - ok0),  32'd1);
        check("t1 cmd_bad count", 32'(cnt_bad - bad0), 32'd0);
        check("t1 reply bytes",   32'(mon_q.size() - rd), 32'(NB));
        expect_reply("t1", 8'h02, 8'hA5, 8'hA7);
        check("t1 gap cycles",    32'(start_q[s0] - last_ok_cyc), 32'(GAP + 1));
        check("t1 busy fall",     32'(at - start_q[s0]), 32'(NB * FRAME));

        // Snapshot: value1 changes right after the decode cycle.
        value1 = 10'h3FF;
        ok0 = cnt_ok;
        fork
            send_byte(8'hA1, 1'b1);
            begin
                for (int i = 0; i < 2 * FRAME; i++) begin
                    @(negedge clk12MHz);
                    if (cmd_ok) break;
                end
                @(posedge clk12MHz); #1 value1 = '0;
            end
        join
        wait_idle("t2", at);
        check("t2 cmd_ok count", 32'(cnt_ok - ok0), 32'd1);
        check("t2 reply bytes",  32'(mon_q.size() - rd), 32'(NB));
        expect_reply("t2", 8'h03, 8'hFF, 8'hFC);

        // Queue: two replies, the third command overruns.
        value2 = 10'h001;
        value4 = 10'h200;
        ok0 = cnt_ok; ovr0 = cnt_ovr; s0 = start_q.size();
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA4, 1'b1);
        send_byte(8'hA1, 1'b1);
        wait_idle("t3", at);
        check("t3 cmd_ok count",  32'(cnt_ok - ok0),  32'd2);
        check("t3 overrun count", 32'(cnt_ovr - ovr0), 32'd1);
        check("t3 reply bytes",   32'(mon_q.size() - rd), 32'(2 * NB));
        expect_reply("t3a", 8'h00, 8'h01, 8'h01);
        expect_reply("t3b", 8'h02, 8'h00, 8'h02);
        check("t3 reply spacing", 32'(start_q[s0 + NB] - start_q[s0]), 32'(NB * FRAME + GAP));

        // Bad byte and framing error: two cmd_bad, no reply.
        ok0 = cnt_ok; bad0 = cnt_bad; q0 = mon_q.size();
        send_byte(8'h55, 1'b1);
        send_byte(8'hA1, 1'b0);
        repeat (3 * CPB) @(negedge clk12MHz);
        check("t4 cmd_bad count", 32'(cnt_bad - bad0), 32'd2);
        check("t4 cmd_ok count",  32'(cnt_ok - ok0),   32'd0);
        check("t4 no tx frames",  32'(mon_q.size() - q0), 32'd0);
        check("t4 busy",          32'(busy), 32'd0);

        // Reset in the middle of byte-0 data bits, then a normal reply.
        value4 = 10'h155;
        s0 = start_q.size();
        send_byte(8'hA4, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (start_q.size() > s0) break;
            @(negedge clk12MHz);
        end
        check("t5 reply started", 32'(start_q.size() - s0), 32'd1);
        repeat (3 * CPB) @(negedge clk12MHz);
        check("t5 tx low before reset", 32'(tx), 32'd0);
        #2 resetq = 1'b0;
        #1;
        check("t5 tx at reset",   32'(tx),   32'd1);
        check("t5 busy at reset", 32'(busy), 32'd0);
        repeat (5) @(negedge clk12MHz);
        resetq = 1'b1;
        repeat (12 * CPB) @(negedge clk12MHz);
        rd  = mon_q.size();
        ok0 = cnt_ok;
        send_byte(8'hA4, 1'b1);
        wait_idle("t5", at);
        check("t5 cmd_ok count", 32'(cnt_ok - ok0), 32'd1);
        check("t5 reply bytes",  32'(mon_q.size() - rd), 32'(NB));
        expect_reply("t5", 8'h01, 8'h55, 8'h54);

        // Channel 2 = 0x1C3: checksum byte 0xC2 when enabled.
        value2 = 10'h1C3;
        ok0 = cnt_ok;
        send_byte(8'hA2, 1'b1);
        wait_idle("t6", at);
        check("t6 cmd_ok count", 32'(cnt_ok - ok0), 32'd1);
        check("t6 reply bytes",  32'(mon_q.size() - rd), 32'(NB));
        expect_reply("t6", 8'h01, 8'hC3, 8'hC2);

        check("stop bit errors", 32'(stop_errs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
- UART-side responder for the ADC query protocol: the far end of the link that `AdcReader` initiates on.
- Receives 8N1 command bytes on `rx`, decodes channel reads 0xA1..0xA4, and replies on `tx` with the selected 10-bit value as two bytes.
- Used as a board-controller stand-in:
  - in simulation benches, wired back-to-back with the reader;
  - in loopback builds on the FPGA, where the values come from fabric registers.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200 baud, truncated).
- RESP_GAP, 16, idle clocks between command stop-bit sample and reply start bit.
- VALUE_W, 10, width of each channel value.

Ports:
- clk12MHz  in  1  system clock, 12 MHz
- resetq  in  1  asynchronous, active-low reset
- rx  in  1  UART command input, idle high, asynchronous to clk12MHz
- tx  out  1  UART reply output, idle high
- value1  in  VALUE_W  channel 1 value
- value2  in  VALUE_W  channel 2 value
- value3  in  VALUE_W  channel 3 value
- value4  in  VALUE_W  channel 4 value
- cmd_ok  out  1  one-cycle pulse: valid read command accepted
- cmd_bad  out  1  one-cycle pulse: byte received but not 0xA1..0xA4, or framing error
- overrun  out  1  one-cycle pulse: valid command dropped because the queue was full
- busy  out  1  high while a reply is pending or transmitting

Behaviour:
- Reset (resetq low, asynchronous): all state is cleared immediately.
  - tx=1; cmd_ok=cmd_bad=overrun=busy=0.
  - RX and TX FSMs go to IDLE; pending slot is emptied.
  - Reset mid-frame aborts the frame; tx returns high within the same cycle resetq falls.
- RX front end:
  - rx passes through a 2-flop synchronizer.
  - Start is detected on a falling edge of the synchronized signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START: wait CLKS_PER_BIT/2 clocks, then resample. If the line is high, treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample 8 bits LSB first, each CLKS_PER_BIT clocks apart.
  - STOP: sample the stop bit CLKS_PER_BIT clocks after the last data bit.
    - Stop bit 0 -> cmd_bad pulse, byte discarded.
- Decode, in the cycle after the stop-bit sample:
  - byte 0xA0+n with n in 1..4 -> the command is valid.
  - any other byte -> cmd_bad pulse.
  - The value of channel n is snapshotted in that same cycle. Later changes to value1..4 do not affect this reply.
- Queue: one active reply plus one pending slot.
  - Valid command while TX is idle -> cmd_ok, starts the RESP_GAP countdown.
  - Valid command while TX is busy and the slot is empty -> cmd_ok, snapshot stored in the slot.
  - Valid command while the slot is full -> overrun pulse, command dropped. Nothing is overwritten.
- TX FSM: IDLE -> GAP -> START -> DATA -> STOP -> (next byte | IDLE).
  - GAP: RESP_GAP clocks with tx=1.
  - Byte 0 = {(8-(VALUE_W-8)) zero bits, v[VALUE_W-1:8]}; byte 1 = v[7:0].
  - Each bit lasts exactly CLKS_PER_BIT clocks.
  - Stop bits are 1. There is no gap between byte 0's stop bit and byte 1's start bit.
  - After the last stop bit: if the slot is full, go to GAP with the slot's value and empty the slot; otherwise go to IDLE.
- busy = (TX FSM != IDLE) | slot full.
  - It rises in the cycle after cmd_ok and falls in the cycle after the final stop bit completes with no pending reply.
- RX runs independently of TX, so full-duplex is supported.
  - If a command is decoded in the same cycle the TX FSM finishes: the slot moves into TX first, then the new command takes the freed slot. No overrun in that case.
- Counter widths: $clog2(CLKS_PER_BIT) bit timer, 3-bit bit index, $clog2(RESP_GAP+1) gap timer. Timers reload; no free-running wrap.

Optional Feature:
- ADC_RESP_CHECKSUM_EN defined: each reply carries a third byte, byte0 XOR byte1, sent back-to-back after byte 1. busy covers all three bytes.
- Not defined: replies are exactly two bytes. The checksum logic is absent.

Decomposition:
- Package adc_proto_pkg holds:
  - CMD_BASE=8'hA0, NUM_CH=4, VALUE_W=10;
  - the RX and TX state encodings;
  - the reply byte-count constant (2, or 3 under ADC_RESP_CHECKSUM_EN).
- Sub-module adc_uart_tx: byte-serializer with a start/ready handshake and the CLKS_PER_BIT timer. The top level sequences bytes and the queue.
- RX stays inline.

Test Plan:
- Reset, with value3=10'h2A5, send 0xA3 -> cmd_ok pulse; after RESP_GAP clocks, tx frames 0x02 then 0xA5; busy drops after the second stop bit.
- Send 0xA1 with value1=10'h3FF, then change value1 to 0 one cycle after cmd_ok -> reply is still 0x03, 0xFF.
- Send 0xA2, 0xA4, 0xA1 back-to-back (value2=1, value4=10'h200) -> replies 0x00,0x01 then 0x02,0x00; third command gives an overrun pulse and no third reply.
- Send 0x55, then 0xA1 with stop bit forced 0 -> two cmd_bad pulses, no cmd_ok, tx stays high.
- Assert resetq low mid-way through the byte-0 data bits -> tx=1 and busy=0 immediately; a fresh 0xA4 afterwards is answered normally.
- With ADC_RESP_CHECKSUM_EN and value2=10'h1C3, send 0xA2 -> bytes 0x01, 0xC3, 0xC2.
